// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and the default word width.
package word_serializer_pkg;

  localparam int unsigned DefaultWidth = 16;

  // Encoding values are fixed so that state dumps stay comparable across revisions.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/word_serializer_if.sv
// Parallel-in / serial-out link bundle for the word serializer.
//   in, start, ready        : parallel word handshake (start accepted when start && ready)
//   sdata, svalid, sready   : serial bit stream, one bit per beat (svalid && sready)
//   sfirst, slast           : framing flags qualifying sdata
//   done                    : one-cycle pulse after the last beat of a word
// master: the client that supplies words and consumes bits. slave: the serializer.
interface word_serializer_if
  import word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic [WIDTH-1:0] in;
  logic             start;
  logic             ready;
  logic             sdata;
  logic             svalid;
  logic             sready;
  logic             sfirst;
  logic             slast;
  logic             done;

  modport master (
    output in, start, sready,
    input  ready, sdata, svalid, sfirst, slast, done
  );

  modport slave (
    input  in, start, sready,
    output ready, sdata, svalid, sfirst, slast, done
  );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register that presents the next outgoing bit.
//   clk, rst_n : clock and synchronous active-low reset (clears the word)
//   load       : capture d (has priority over shift)
//   shift      : advance one bit toward the output end, zero fill
//   d          : parallel word
//   q_bit      : bit currently at the output end
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] word_d, word_q;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = d;
    end else if (shift) begin
      word_d = LSB_FIRST ? (word_q >> 1) : (word_q << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_bit = LSB_FIRST ? word_q[0] : word_q[WIDTH-1];

endmodule

// File: rtl/word_serializer.sv
// Captures a parallel word and sends it one bit per accepted beat over a valid/ready link.
//   clk, rst_n : clock and synchronous active-low reset (aborts any word in flight)
//   bus        : slave side of word_serializer_if (word handshake, serial stream, done pulse)
// All outputs decode from registered state; sready only steers the next state.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  word_serializer_if.slave     bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            load, shift, q_bit;
  logic            ready, svalid, sdata, sfirst, slast, done;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .d     (bus.in),
    .q_bit (q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    ready   = 1'b0;
    svalid  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        svalid = 1'b1;
        if (bus.sready) begin
          shift = 1'b1;
          // Leave the FSM before the counter would wrap.
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate data and flags so nothing but svalid-qualified values leave the block.
  assign sdata  = svalid & q_bit;
  assign sfirst = svalid & (cnt_q == '0);
  assign slast  = svalid & (cnt_q == LastCnt);

  assign bus.ready  = ready;
  assign bus.svalid = svalid;
  assign bus.sdata  = sdata;
  assign bus.sfirst = sfirst;
  assign bus.slast  = slast;
  assign bus.done   = done;

endmodule
